onchip_mem_read_cache: RTL and testbench
========================================

Name: onchip_mem_read_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache placed directly upstream of the on-chip memory slave.
- Accepts word-addressed Avalon-MM pipelined requests from the CPU data master.
- Serves read hits from local flop storage; forwards misses and all writes to the memory using its fixed 1-cycle read latency.
- Lets the team measure how data-dependent access patterns affect hit rate and latency.

Parameters:
- ADDR_W, 17, word address width; matches the memory address port.
- DATA_W, 32, data width; byte enable width is DATA_W/8.
- LINES_LOG2, 6, log2 of line count (64 lines of one word each); tag width is ADDR_W-LINES_LOG2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  ADDR_W  CPU word address
- s_read  in  1  read request
- s_write  in  1  write request
- s_byteenable  in  4  write byte lanes
- s_writedata  in  32  write data
- s_waitrequest  out  1  request not accepted this cycle
- s_readdata  out  32  read data
- s_readdatavalid  out  1  s_readdata valid
- flush  in  1  invalidate all lines
- m_address  out  ADDR_W  memory address
- m_byteenable  out  4  memory byte enables
- m_chipselect  out  1  memory select
- m_write  out  1  memory write
- m_writedata  out  32  memory write data
- m_clken  out  1  memory clock enable
- m_readdata  in  32  memory read data, valid 1 cycle after chipselect with write low

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - all valid bits 0; FSM in IDLE
  - s_readdatavalid=0, s_readdata=0
  - m_chipselect=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0
  - s_waitrequest=1
- m_clken is a constant 1.
- Index is s_address[LINES_LOG2-1:0]; tag is the upper bits.
- hit = valid[index] & (tag_mem[index] == tag). Lookup is combinational in IDLE.
- s_waitrequest is 1 in every cycle except the accept cycles listed below.

FSM states:
- IDLE:
  - s_write → latch request and hit flag, go to WR. s_write has priority if s_read and s_write are both high (illegal; must not hang).
  - s_read & hit → s_waitrequest=0 (accept); next cycle s_readdatavalid=1 with the line data. Stay in IDLE, so back-to-back hits give 1 result per cycle.
  - s_read & miss → latch address, go to MREQ.
- MREQ: m_chipselect=1, m_write=0, m_byteenable=4'hF, m_address=latched address → MCAP.
- MCAP:
  - Write m_readdata into the line; set tag and valid.
  - s_waitrequest=0 (accept).
  - Next cycle: s_readdatavalid=1, s_readdata=captured word.
  - → IDLE.
  - Miss timing: request at T, chipselect at T+1, accept at T+2, data at T+3.
- WR:
  - m_chipselect=1, m_write=1, m_address/m_byteenable/m_writedata from latched request.
  - s_waitrequest=0 (accept).
  - If the latched hit flag is set, merge the enabled bytes into the line. Misses do not allocate.
  - → IDLE. Writes take 2 cycles.

Rules and boundaries:
- m_* outputs are registered and deasserted in every state except MREQ and WR.
- s_readdatavalid is a single-cycle pulse per accepted read.
- flush (any state) clears all valid bits at the clock edge.
  - A fill completing in the same cycle still returns its data, but the line stays invalid: flush wins.
  - A hit accepted in the flush cycle returns the pre-flush data.
- Write hit followed by a read of the same address on the next cycle must return the merged data.
- Address wrap: index/tag split only; no boundary special case. Address 0x1FFFF is legal.
- Reset asserted mid-fill or mid-write aborts immediately to the reset values; no readdatavalid is produced.

Optional Feature:
- Macro: ONCHIP_CACHE_STATS_EN.
- Defined:
  - Adds input stats_clr and outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each accepted read hit; miss_count increments on each MREQ entry.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset or stats_clr. stats_clr has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read 0x00040 → m_chipselect at T+1 with m_address=0x00040; memory returns 0xDEADBEEF; s_readdatavalid at T+3 with 0xDEADBEEF; miss_count=1.
- Repeat read 0x00040 → s_waitrequest=0 same cycle, 0xDEADBEEF at T+1, no m_chipselect, hit_count=1. Then read 0x00080 (same index, different tag) → miss, and the line is replaced.
- Write 0x00040 byteenable=4'b0011 data 0x12345678 → m_write pulse with those values; the following read returns 0xDEAD5678 as a hit.
- Write to uncached 0x00100 → forwarded to memory; the next read of 0x00100 is a miss (no allocate).
- Pulse flush after filling 4 lines → all four re-reads miss; flush in an MCAP cycle still delivers the data, but the next read of that address misses.
- Assert reset during MREQ → all outputs return to reset values asynchronously; no s_readdatavalid; the first read after reset misses.

Source files
------------

// File: rtl/onchip_mem_read_cache.sv
// Direct-mapped write-through read cache in front of a 1-cycle on-chip memory; hits return next cycle,
// misses in 3 cycles, writes take 2. Optional hit/miss counters are enabled by ONCHIP_CACHE_STATS_EN.
module onchip_mem_read_cache #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int LINES_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [DATA_W-1:0]     s_writedata,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
`ifdef ONCHIP_CACHE_STATS_EN
  input  logic                  stats_clr,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  input  logic [DATA_W-1:0]     m_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = ADDR_W - LINES_LOG2;

  typedef enum logic [1:0] {IDLE, MREQ, MCAP, WR} state_t;

  state_t state, state_next;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [LINES_LOG2-1:0] idx, req_idx;
  logic [TAG_W-1:0]      tag, req_tag;
  logic                  hit;

  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_data;
  logic              req_hit;

  logic accept, hit_acc, miss_start, wr_start;

  assign idx     = s_address[LINES_LOG2-1:0];
  assign tag     = s_address[ADDR_W-1:LINES_LOG2];
  assign req_idx = req_addr[LINES_LOG2-1:0];
  assign req_tag = req_addr[ADDR_W-1:LINES_LOG2];
  assign hit     = valid[idx] && (tag_mem[idx] == tag);

  assign m_clken       = 1'b1;
  assign s_waitrequest = ~accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Writes win over a simultaneous read so an illegal read+write still completes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit_acc    = 1'b0;
    miss_start = 1'b0;
    wr_start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_write) begin
          state_next = WR;
          wr_start   = 1'b1;
        end else if (s_read) begin
          if (hit) begin
            accept  = 1'b1;
            hit_acc = 1'b1;
          end else begin
            state_next = MREQ;
            miss_start = 1'b1;
          end
        end
      end
      MREQ: state_next = MCAP;
      MCAP: begin
        state_next = IDLE;
        accept     = 1'b1;
      end
      WR: begin
        state_next = IDLE;
        accept     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs are only non-zero while in MREQ or WR, which are entered only from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_writedata  <= '0;
    end else begin
      m_chipselect <= miss_start | wr_start;
      m_write      <= wr_start;
      m_address    <= (miss_start | wr_start) ? s_address : '0;
      m_byteenable <= wr_start ? s_byteenable : (miss_start ? {BE_W{1'b1}} : '0);
      m_writedata  <= wr_start ? s_writedata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr <= '0;
      req_be   <= '0;
      req_data <= '0;
      req_hit  <= 1'b0;
    end else if (miss_start | wr_start) begin
      req_addr <= s_address;
      req_be   <= s_byteenable;
      req_data <= s_writedata;
      req_hit  <= hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= hit_acc | (state == MCAP);
      if (hit_acc)
        s_readdata <= data_mem[idx];
      else if (state == MCAP)
        s_readdata <= m_readdata;
    end
  end

  // Flush beats a fill completing in the same cycle: the data is returned but the line stays invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid <= '0;
    else if (flush)
      valid <= '0;
    else if (state == MCAP)
      valid[req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == MCAP) begin
      data_mem[req_idx] <= m_readdata;
      tag_mem[req_idx]  <= req_tag;
    end else if (state == WR && req_hit) begin
      for (int b = 0; b < BE_W; b++)
        if (req_be[b])
          data_mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
    end
  end

`ifdef ONCHIP_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (miss_start && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_read_cache.sv
// Directed bench for onchip_mem_read_cache with a behavioural 1-cycle memory behind it.
module tb_onchip_mem_read_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] s_address = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [3:0]  s_byteenable = '0;
  logic [31:0] s_writedata = '0;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        flush = 1'b0;
  logic [16:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_clken;
  logic [31:0] m_readdata = '0;
`ifdef ONCHIP_CACHE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors = 0;
  int errors  = 0;

  onchip_mem_read_cache dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .flush(flush),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken),
`ifdef ONCHIP_CACHE_STATS_EN
    .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count),
`endif
    .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as A5000000 | address.
  logic [31:0] mem [logic [16:0]];
  logic [31:0] wtmp;

  function automatic logic [31:0] mem_val(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA500_0000 | {15'd0, a};
  endfunction

  always @(posedge clk) begin
    if (m_chipselect) begin
      if (m_write) begin
        wtmp = mem_val(m_address);
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) wtmp[8*b +: 8] = m_writedata[8*b +: 8];
        mem[m_address] = wtmp;
      end else begin
        m_readdata <= mem_val(m_address);
      end
    end
  end

  // Cycle 0 is the request cycle; -1 means the event never happened within the bound.
  task automatic do_read(input logic [16:0] a, output logic [31:0] d, output int acc, output int dv,
                         output int cs, output logic [16:0] cs_addr, output logic [3:0] cs_be,
                         output logic extra);
    d = '0; acc = -1; dv = -1; cs = -1; cs_addr = '0; cs_be = '0; extra = 1'b0;
    s_address = a;
    s_read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_chipselect && cs < 0) begin cs = k; cs_addr = m_address; cs_be = m_byteenable; end
      if (s_readdatavalid && dv < 0) begin dv = k; d = s_readdata; end
      if (!s_waitrequest && acc < 0) acc = k;
      @(posedge clk); #1;
      if (acc == k) s_read = 1'b0;
      if (dv >= 0) break;
    end
    s_read = 1'b0;
    @(negedge clk);
    extra = s_readdatavalid;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [3:0] be, input logic [31:0] wd,
                          input logic rd_too, output int acc, output logic mw,
                          output logic [16:0] ma, output logic [3:0] mbe, output logic [31:0] mwd);
    acc = -1; mw = 1'b0; ma = '0; mbe = '0; mwd = '0;
    s_address = a; s_byteenable = be; s_writedata = wd;
    s_write = 1'b1;
    s_read = rd_too;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!s_waitrequest) begin
        acc = k; mw = m_write & m_chipselect; ma = m_address; mbe = m_byteenable; mwd = m_writedata;
      end
      @(posedge clk); #1;
      if (acc >= 0) break;
    end
    s_write = 1'b0;
    s_read = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b want 1", s_waitrequest); end
    vectors++; if (s_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b want 0", s_readdatavalid); end
    vectors++; if (s_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", s_readdata); end
    vectors++; if ({m_chipselect, m_write} !== 2'b00) begin errors++; $display("FAIL rst_cs_wr: got %b want 00", {m_chipselect, m_write}); end
    vectors++; if ({m_address, m_byteenable, m_writedata} !== 53'h0) begin errors++; $display("FAIL rst_m_bus: got %h/%h/%h want 0", m_address, m_byteenable, m_writedata); end
    vectors++; if (m_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b want 1", m_clken); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_fill();
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    do_read(17'h00040, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1) begin errors++; $display("FAIL miss_cs_cycle: got %0d want 1", cs); end
    vectors++; if ({ca, cb} !== {17'h00040, 4'hF}) begin errors++; $display("FAIL miss_m_addr_be: got %h/%h want 00040/f", ca, cb); end
    vectors++; if (acc !== 2) begin errors++; $display("FAIL miss_accept_cycle: got %0d want 2", acc); end
    vectors++; if (dv !== 3) begin errors++; $display("FAIL miss_rdv_cycle: got %0d want 3", dv); end
    vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data: got %h want deadbeef", d); end
    vectors++; if (ex !== 1'b0) begin errors++; $display("FAIL miss_rdv_pulse: got %b want 0", ex); end
`ifdef ONCHIP_CACHE_STATS_EN
    vectors++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss_count: got %0d want 1", miss_count); end
`endif
  endtask

  task automatic test_hit();
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    do_read(17'h00040, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (acc !== 0) begin errors++; $display("FAIL hit_accept_cycle: got %0d want 0", acc); end
    vectors++; if (dv !== 1) begin errors++; $display("FAIL hit_rdv_cycle: got %0d want 1", dv); end
    vectors++; if (cs !== -1) begin errors++; $display("FAIL hit_no_cs: got %0d want -1", cs); end
    vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data: got %h want deadbeef", d); end
`ifdef ONCHIP_CACHE_STATS_EN
    vectors++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_count: got %0d want 1", hit_count); end
`endif
  endtask

  task automatic test_replace();
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    mem[17'h00080] = 32'h0BADF00D;
    do_read(17'h00080, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1 || d !== 32'h0BADF00D) begin errors++; $display("FAIL replace_miss: got cs=%0d d=%h want cs=1 d=0badf00d", cs, d); end
    do_read(17'h00040, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL replace_evicted: got cs=%0d d=%h want cs=1 d=deadbeef", cs, d); end
  endtask

  task automatic test_write_hit();
    int acc, dv, cs; logic mw; logic [16:0] ma; logic [3:0] mbe; logic [31:0] mwd, d;
    logic [16:0] ca; logic [3:0] cb; logic ex;
    do_write(17'h00040, 4'b0011, 32'h12345678, 1'b0, acc, mw, ma, mbe, mwd);
    vectors++; if (acc !== 1) begin errors++; $display("FAIL wr_accept_cycle: got %0d want 1", acc); end
    vectors++; if ({mw, ma, mbe, mwd} !== {1'b1, 17'h00040, 4'b0011, 32'h12345678}) begin
      errors++; $display("FAIL wr_m_bus: got w=%b a=%h be=%h d=%h want 1/00040/3/12345678", mw, ma, mbe, mwd); end
    do_read(17'h00040, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== -1 || acc !== 0) begin errors++; $display("FAIL wr_then_read_hit: got cs=%0d acc=%0d want -1/0", cs, acc); end
    vectors++; if (d !== 32'hDEAD5678) begin errors++; $display("FAIL wr_merge_data: got %h want dead5678", d); end
  endtask

  task automatic test_write_miss();
    int acc, dv, cs; logic mw; logic [16:0] ma; logic [3:0] mbe; logic [31:0] mwd, d;
    logic [16:0] ca; logic [3:0] cb; logic ex;
    do_write(17'h00100, 4'hF, 32'hCAFEF00D, 1'b0, acc, mw, ma, mbe, mwd);
    vectors++; if (acc !== 1 || mw !== 1'b1 || ma !== 17'h00100) begin
      errors++; $display("FAIL wmiss_fwd: got acc=%0d w=%b a=%h want 1/1/00100", acc, mw, ma); end
    do_read(17'h00100, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1 || d !== 32'hCAFEF00D) begin errors++; $display("FAIL wmiss_no_alloc: got cs=%0d d=%h want 1/cafef00d", cs, d); end
    do_write(17'h00200, 4'hF, 32'h11112222, 1'b1, acc, mw, ma, mbe, mwd);
    vectors++; if (acc !== 1 || mw !== 1'b1 || ma !== 17'h00200) begin
      errors++; $display("FAIL rw_conflict: got acc=%0d w=%b a=%h want 1/1/00200", acc, mw, ma); end
    do_read(17'h00200, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1 || d !== 32'h11112222) begin errors++; $display("FAIL rw_conflict_read: got cs=%0d d=%h want 1/11112222", cs, d); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] adr [4];
    logic [31:0] exp_d [4];
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    adr[0] = 17'h00001; adr[1] = 17'h00002; adr[2] = 17'h00003; adr[3] = 17'h1FFFF;
    exp_d[0] = 32'hA5000001; exp_d[1] = 32'hA5000002; exp_d[2] = 32'hA5000003; exp_d[3] = 32'hA501FFFF;
    for (int i = 0; i < 4; i++) begin
      do_read(adr[i], d, acc, dv, cs, ca, cb, ex);
      vectors++; if (cs !== 1 || ca !== adr[i] || d !== exp_d[i]) begin
        errors++; $display("FAIL b2b_fill%0d: got cs=%0d a=%h d=%h want 1/%h/%h", i, cs, ca, d, adr[i], exp_d[i]); end
    end
    s_address = adr[0];
    s_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        vectors++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_accept%0d: got %b want 0", k, s_waitrequest); end
      end
      if (k >= 1) begin
        vectors++; if ({s_readdatavalid, s_readdata} !== {1'b1, exp_d[k-1]}) begin
          errors++; $display("FAIL b2b_data%0d: got v=%b d=%h want 1/%h", k - 1, s_readdatavalid, s_readdata, exp_d[k-1]); end
      end
      @(posedge clk); #1;
      if (k + 1 < 4) s_address = adr[k+1];
      else s_read = 1'b0;
    end
  endtask

  task automatic test_flush();
    logic [16:0] adr [4];
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    adr[0] = 17'h00001; adr[1] = 17'h00002; adr[2] = 17'h00003; adr[3] = 17'h1FFFF;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read(adr[i], d, acc, dv, cs, ca, cb, ex);
      vectors++; if (cs !== 1) begin errors++; $display("FAIL flush_miss%0d: got cs=%0d want 1", i, cs); end
    end
  endtask

  task automatic test_flush_corner();
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    // Flush lands on the MCAP cycle of a fill.
    s_address = 17'h00005;
    s_read = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL fl_mcap_accept: got %b want 0", s_waitrequest); end
    @(posedge clk); #1;
    flush = 1'b0;
    s_read = 1'b0;
    @(negedge clk);
    vectors++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'hA5000005}) begin
      errors++; $display("FAIL fl_mcap_data: got v=%b d=%h want 1/a5000005", s_readdatavalid, s_readdata); end
    @(posedge clk); #1;
    do_read(17'h00005, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1) begin errors++; $display("FAIL fl_mcap_invalid: got cs=%0d want 1", cs); end
    // A hit accepted together with flush returns the pre-flush data.
    s_address = 17'h00005;
    s_read = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL fl_hit_accept: got %b want 0", s_waitrequest); end
    @(posedge clk); #1;
    s_read = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    vectors++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'hA5000005}) begin
      errors++; $display("FAIL fl_hit_data: got v=%b d=%h want 1/a5000005", s_readdatavalid, s_readdata); end
    @(posedge clk); #1;
    do_read(17'h00005, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1) begin errors++; $display("FAIL fl_hit_invalid: got cs=%0d want 1", cs); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int acc, dv, cs; logic [16:0] ca; logic [3:0] cb; logic ex;
    logic seen_rdv;
    seen_rdv = 1'b0;
    s_address = 17'h00007;
    s_read = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (m_chipselect !== 1'b1 || m_address !== 17'h00007) begin
      errors++; $display("FAIL rmid_in_mreq: got cs=%b a=%h want 1/00007", m_chipselect, m_address); end
    #1 reset = 1'b1;
    #1;
    vectors++; if ({m_chipselect, m_write, m_address, m_byteenable} !== 23'h0) begin
      errors++; $display("FAIL rmid_async_m: got cs=%b a=%h be=%h want 0", m_chipselect, m_address, m_byteenable); end
    vectors++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rmid_waitreq: got %b want 1", s_waitrequest); end
    s_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (s_readdatavalid) seen_rdv = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (s_readdatavalid) seen_rdv = 1'b1;
    end
    vectors++; if (seen_rdv !== 1'b0) begin errors++; $display("FAIL rmid_no_rdv: got %b want 0", seen_rdv); end
    @(posedge clk); #1;
    do_read(17'h00005, d, acc, dv, cs, ca, cb, ex);
    vectors++; if (cs !== 1 || d !== 32'hA5000005) begin errors++; $display("FAIL rmid_first_miss: got cs=%0d d=%h want 1/a5000005", cs, d); end
  endtask

`ifdef ONCHIP_CACHE_STATS_EN
  task automatic test_stats_clr();
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    vectors++; if ({hit_count, miss_count} !== 64'h0) begin
      errors++; $display("FAIL stats_clr: got %0d/%0d want 0/0", hit_count, miss_count); end
  endtask
`endif

  initial begin
    mem[17'h00040] = 32'hDEADBEEF;
    test_reset();
    test_miss_fill();
    test_hit();
    test_replace();
    test_write_hit();
    test_write_miss();
    test_back_to_back();
    test_flush();
    test_flush_corner();
    test_reset_mid();
`ifdef ONCHIP_CACHE_STATS_EN
    test_stats_clr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
